// File: rtl/endian_swap_stream.sv
// Streaming bit/byte-order converter with a per-word transform mode.
// Results are held in a 2-entry FIFO, and a wrapping counter tracks completed output handshakes.
module endian_swap_stream #(
  parameter int WIDTH = 48,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_mode,
  output logic [CNT_W-1:0] xfer_count
);

  localparam int NBYTES = WIDTH / 8;

  if ((WIDTH % 8) != 0 || WIDTH < 8) begin : gBadWidth
    $error("endian_swap_stream: WIDTH must be a non-zero multiple of 8");
  end

  function automatic logic [WIDTH-1:0] swapWord(input logic [WIDTH-1:0] d,
                                                input logic [1:0] m);
    logic [WIDTH-1:0] r;
    r = d;
    case (m)
      2'd1: for (int i = 0; i < WIDTH; i++) r[i] = d[WIDTH-1-i];
      2'd2: for (int k = 0; k < NBYTES; k++) r[8*k +: 8] = d[8*(NBYTES-1-k) +: 8];
      2'd3: for (int k = 0; k < NBYTES; k++)
              for (int j = 0; j < 8; j++) r[8*k+j] = d[8*k+7-j];
      default: r = d;
    endcase
    return r;
  endfunction

  logic [WIDTH-1:0] dataMem [2];
  logic [1:0]       modeMem [2];
  logic             headPtr;
  logic             tailPtr;
  logic [1:0]       occ;
  logic [CNT_W-1:0] xferCnt;
  logic             push;
  logic             pop;

  // Ready depends only on registered occupancy so upstream never sees a path from out_ready.
  assign in_ready   = (occ < 2'd2) && !rst;
  assign out_valid  = (occ != 2'd0);
  assign out_data   = dataMem[headPtr];
  assign out_mode   = modeMem[headPtr];
  assign xfer_count = xferCnt;
  assign push       = in_valid && in_ready;
  assign pop        = out_valid && out_ready && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      dataMem[0] <= '0;
      dataMem[1] <= '0;
      modeMem[0] <= '0;
      modeMem[1] <= '0;
      headPtr    <= 1'b0;
      tailPtr    <= 1'b0;
      occ        <= 2'd0;
      xferCnt    <= '0;
    end else begin
      if (push) begin
        dataMem[tailPtr] <= swapWord(in_data, in_mode);
        modeMem[tailPtr] <= in_mode;
        tailPtr          <= ~tailPtr;
      end
      if (pop) begin
        headPtr <= ~headPtr;
        xferCnt <= xferCnt + 1'b1;
      end
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

endmodule
